// File: rtl/udp_dram_axi_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DRAM writer and the interconnect.
// master = writer side, slave = memory/interconnect side.
interface udp_dram_axi_writer_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/udp_dram_axi_writer.sv
// Drains the UDP receive stage's ctrl/data FIFOs into single-outstanding AXI4 INCR
// write bursts to DRAM, with burst count and sticky error flags for debug.
module udp_dram_axi_writer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_BURST  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [35:0]                  data_dout,
    input  logic                         data_empty,
    output logic                         data_re,
    input  logic [39:0]                  ctrl_dout,
    input  logic                         ctrl_empty,
    output logic                         ctrl_re,
    udp_dram_axi_writer_if.master        m_axi,
    output logic                         busy,
    output logic [31:0]                  burst_cnt,
    output logic                         err_resp,
    output logic                         err_len
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_RESP
    } state_t;

    state_t                state;
    logic [7:0]            len_q;
    logic [7:0]            beat;
    logic                  aw_done;

    logic [7:0]            cmd_len;
    logic                  len_bad;
    logic [31:0]           word_addr;
    logic [ADDR_WIDTH-1:0] aw_addr_next;
    logic                  w_fire;
    logic                  addr_lsb_unused;

    assign cmd_len         = ctrl_dout[39:32];
    assign len_bad         = (cmd_len == 8'd0) || (32'(cmd_len) > MAX_BURST);
    assign word_addr       = {ctrl_dout[31:2], 2'b00};
    assign aw_addr_next    = BASE_ADDR + ADDR_WIDTH'(word_addr);
    assign addr_lsb_unused = ^ctrl_dout[1:0];

    // W side is a direct FWFT passthrough; the head stays put until data_re pops it.
    assign m_axi.wvalid  = (state == S_BURST) && !data_empty && (beat < len_q);
    assign m_axi.wlast   = (state == S_BURST) && (beat == len_q - 8'd1);
    assign m_axi.wdata   = data_dout[31:0];
    assign m_axi.wstrb   = data_dout[35:32];
    assign m_axi.awsize  = 3'b010;
    assign m_axi.awburst = 2'b01;

    assign w_fire  = m_axi.wvalid && m_axi.wready;
    assign data_re = w_fire;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ctrl_re       <= 1'b0;
            m_axi.awvalid <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.awlen   <= '0;
            m_axi.bready  <= 1'b0;
            len_q         <= '0;
            beat          <= '0;
            aw_done       <= 1'b0;
            burst_cnt     <= '0;
            err_resp      <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            ctrl_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ctrl_re is registered, so the head is still visible while it pops.
                    if (!ctrl_empty && !ctrl_re) begin
                        ctrl_re <= 1'b1;
                        if (len_bad) begin
                            err_len <= 1'b1;
                        end else begin
                            len_q         <= cmd_len;
                            m_axi.awlen   <= cmd_len - 8'd1;
                            m_axi.awaddr  <= aw_addr_next;
                            m_axi.awvalid <= 1'b1;
                            beat          <= '0;
                            aw_done       <= 1'b0;
                            state         <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (m_axi.awvalid && m_axi.awready) begin
                        m_axi.awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        beat <= beat + 8'd1;
                    end
                    if (aw_done && (beat == len_q)) begin
                        m_axi.bready <= 1'b1;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp != 2'b00) begin
                            err_resp <= 1'b1;
                        end
                        burst_cnt <= burst_cnt + 32'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
